// File: rtl/posit_simd_decode_pipe_pkg.sv
// Shared definitions for the pipelined multi-precision posit operand decoder.
package posit_pkg;

  localparam logic [1:0] PRE_1X  = 2'b00;
  localparam logic [1:0] PRE_2X  = 2'b01;
  localparam logic [1:0] PRE_4X  = 2'b10;
  localparam logic [1:0] PRE_RSV = 2'b11;

  localparam int ES_DEF      = 2;
  localparam int N_DEF       = 32;
  localparam int SCALE_W_DEF = 8;
  localparam int FRAC_W_DEF  = N_DEF - ES_DEF - 2;

  // Decoded lane record at the default word width.
  typedef struct packed {
    logic                   sign;
    logic                   zero;
    logic                   nar;
    logic [SCALE_W_DEF-1:0] scale;
    logic [FRAC_W_DEF-1:0]  frac;
  } posit_dec_t;

endpackage

// File: rtl/posit_simd_decode_pipe_lane_decode.sv
// Combinational posit decode of one W-bit lane that has already been reduced
// to its two's-complement magnitude; the original sign arrives separately.
module posit_lane_decode #(
  parameter int W       = 32,
  parameter int ES      = 2,
  parameter int SCALE_W = 8,
  parameter int FRAC_W  = 28
) (
  input  logic [W-1:0]       i_mag,
  input  logic               i_sign,
  output logic               o_sign,
  output logic               o_zero,
  output logic               o_nar,
  output logic [SCALE_W-1:0] o_scale,
  output logic [FRAC_W-1:0]  o_frac
);

  localparam int MW = $clog2(W) + 1;
  localparam int TW = W - ES + FRAC_W;

  logic [W-2:0]       w_body;
  logic [W-2:0]       w_inv;
  logic [W-2:0]       w_shift;
  logic [MW-1:0]      w_run;
  logic [SCALE_W-1:0] w_k;
  logic [ES-1:0]      w_exp;
  logic [TW-1:0]      w_ftmp;
  logic               w_zero;
  logic               w_nar;

  assign w_body = i_mag[W-2:0];
  // A run of ones becomes a run of zeros, so one leading-one detector serves both regimes.
  assign w_inv  = w_body[W-2] ? ~w_body : w_body;

  // Leading-one detector: run length of the regime (whole body when unterminated).
  always_comb begin
    w_run = MW'(W - 1);
    for (int i = 0; i < W - 1; i++) begin
      w_run = w_inv[i] ? MW'(W - 2 - i) : w_run;
    end
  end

  assign w_shift = w_body << (w_run + MW'(1));
  assign w_exp   = ES'(w_shift >> (W - 1 - ES));
  assign w_ftmp  = {1'b1, w_shift[W-2-ES:0], {FRAC_W{1'b0}}};
  assign w_k     = w_body[W-2] ? (SCALE_W'(w_run) - SCALE_W'(1)) : (SCALE_W'(0) - SCALE_W'(w_run));
  assign w_zero  = (i_mag == {W{1'b0}});
  assign w_nar   = (i_mag == {1'b1, {(W-1){1'b0}}});

  // Special encodings override the regular regime/exponent/fraction fields.
  always_comb begin
    if (w_zero || w_nar) begin
      o_sign  = w_nar;
      o_zero  = w_zero;
      o_nar   = w_nar;
      o_scale = {SCALE_W{1'b0}};
      o_frac  = {FRAC_W{1'b0}};
    end else begin
      o_sign  = i_sign;
      o_zero  = 1'b0;
      o_nar   = 1'b0;
      o_scale = (w_k << ES) + SCALE_W'(w_exp);
      o_frac  = FRAC_W'(w_ftmp >> (TW - FRAC_W));
    end
  end

endmodule

// File: rtl/posit_simd_decode_pipe.sv
// Two-stage elastic posit decoder: S1 splits lanes and takes magnitudes,
// S2 registers the per-lane regime/exponent/fraction decode.
module posit_simd_decode_pipe
  import posit_pkg::*;
#(
  parameter int N       = 32,
  parameter int ES      = ES_DEF,
  parameter int SCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_pre,
  input  logic [N-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_pre,
  output logic                  out_err,
  output logic [3:0]            out_sign,
  output logic [3:0]            out_zero,
  output logic [3:0]            out_nar,
  output logic [4*SCALE_W-1:0]  out_scale,
  output logic [4*(N-ES-2)-1:0] out_frac
);

  localparam int FRAC_W = N - ES - 2;
  localparam int W2     = N / 2;
  localparam int W4     = N / 4;

  logic w_ready1, w_ready2;
  logic w_err;
  logic [1:0] w_pre;
  logic [N-1:0] w_mag1, w_mag2, w_mag4;

  logic r1_valid, r1_err, r1_sgn1;
  logic [1:0] r1_pre, r1_sgn2;
  logic [3:0] r1_sgn4;
  logic [N-1:0] r1_mag1, r1_mag2, r1_mag4;

  logic w_d1_sign, w_d1_zero, w_d1_nar;
  logic [SCALE_W-1:0] w_d1_scale;
  logic [FRAC_W-1:0] w_d1_frac;
  logic [1:0] w_d2_sign, w_d2_zero, w_d2_nar;
  logic [2*SCALE_W-1:0] w_d2_scale;
  logic [2*FRAC_W-1:0] w_d2_frac;
  logic [3:0] w_d4_sign, w_d4_zero, w_d4_nar;
  logic [4*SCALE_W-1:0] w_d4_scale;
  logic [4*FRAC_W-1:0] w_d4_frac;

  logic [3:0] w_ln_sign, w_ln_zero, w_ln_nar;
  logic [4*SCALE_W-1:0] w_ln_scale;
  logic [4*FRAC_W-1:0] w_ln_frac;

  logic r2_valid, r2_err;
  logic [1:0] r2_pre;
  logic [3:0] r2_sign, r2_zero, r2_nar;
  logic [4*SCALE_W-1:0] r2_scale;
  logic [4*FRAC_W-1:0] r2_frac;

  assign w_ready2 = !r2_valid || out_ready;
  assign w_ready1 = !r1_valid || w_ready2;
  assign in_ready = w_ready1;

  assign w_err = (in_pre == PRE_RSV);
  assign w_pre = w_err ? PRE_1X : in_pre;

  // Two's-complement magnitude of every lane split, one word per precision.
  always_comb begin
    w_mag1 = in_data[N-1] ? ({N{1'b0}} - in_data) : in_data;
    w_mag2 = {N{1'b0}};
    w_mag4 = {N{1'b0}};
    for (int i = 0; i < 2; i++) begin
      w_mag2[i*W2 +: W2] = in_data[i*W2+W2-1] ? ({W2{1'b0}} - in_data[i*W2 +: W2])
                                               : in_data[i*W2 +: W2];
    end
    for (int i = 0; i < 4; i++) begin
      w_mag4[i*W4 +: W4] = in_data[i*W4+W4-1] ? ({W4{1'b0}} - in_data[i*W4 +: W4])
                                               : in_data[i*W4 +: W4];
    end
  end

  // Stage 1 register: lane split, signs and magnitudes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_err   <= 1'b0;
      r1_pre   <= 2'b00;
      r1_sgn1  <= 1'b0;
      r1_sgn2  <= 2'b00;
      r1_sgn4  <= 4'b0000;
      r1_mag1  <= {N{1'b0}};
      r1_mag2  <= {N{1'b0}};
      r1_mag4  <= {N{1'b0}};
    end else if (w_ready1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_err  <= w_err;
        r1_pre  <= w_pre;
        r1_sgn1 <= in_data[N-1];
        r1_sgn2 <= {in_data[N-1], in_data[W2-1]};
        r1_sgn4 <= {in_data[N-1], in_data[3*W4-1], in_data[W2-1], in_data[W4-1]};
        r1_mag1 <= w_mag1;
        r1_mag2 <= w_mag2;
        r1_mag4 <= w_mag4;
      end
    end
  end

  posit_lane_decode #(.W(N), .ES(ES), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) u_dec1 (
    .i_mag(r1_mag1), .i_sign(r1_sgn1), .o_sign(w_d1_sign), .o_zero(w_d1_zero),
    .o_nar(w_d1_nar), .o_scale(w_d1_scale), .o_frac(w_d1_frac)
  );

  for (genvar g = 0; g < 2; g++) begin : g_dec2
    posit_lane_decode #(.W(W2), .ES(ES), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) u_dec (
      .i_mag(r1_mag2[g*W2 +: W2]), .i_sign(r1_sgn2[g]), .o_sign(w_d2_sign[g]),
      .o_zero(w_d2_zero[g]), .o_nar(w_d2_nar[g]),
      .o_scale(w_d2_scale[g*SCALE_W +: SCALE_W]), .o_frac(w_d2_frac[g*FRAC_W +: FRAC_W])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_dec4
    posit_lane_decode #(.W(W4), .ES(ES), .SCALE_W(SCALE_W), .FRAC_W(FRAC_W)) u_dec (
      .i_mag(r1_mag4[g*W4 +: W4]), .i_sign(r1_sgn4[g]), .o_sign(w_d4_sign[g]),
      .o_zero(w_d4_zero[g]), .o_nar(w_d4_nar[g]),
      .o_scale(w_d4_scale[g*SCALE_W +: SCALE_W]), .o_frac(w_d4_frac[g*FRAC_W +: FRAC_W])
    );
  end

  // Lane mux: lanes beyond the active lane count stay all-zero.
  always_comb begin
    w_ln_sign  = 4'b0000;
    w_ln_zero  = 4'b0000;
    w_ln_nar   = 4'b0000;
    w_ln_scale = {(4*SCALE_W){1'b0}};
    w_ln_frac  = {(4*FRAC_W){1'b0}};
    case (r1_pre)
      PRE_1X: begin
        w_ln_sign[0]             = w_d1_sign;
        w_ln_zero[0]             = w_d1_zero;
        w_ln_nar[0]              = w_d1_nar;
        w_ln_scale[SCALE_W-1:0]  = w_d1_scale;
        w_ln_frac[FRAC_W-1:0]    = w_d1_frac;
      end
      PRE_2X: begin
        w_ln_sign[1:0]            = w_d2_sign;
        w_ln_zero[1:0]            = w_d2_zero;
        w_ln_nar[1:0]             = w_d2_nar;
        w_ln_scale[2*SCALE_W-1:0] = w_d2_scale;
        w_ln_frac[2*FRAC_W-1:0]   = w_d2_frac;
      end
      PRE_4X: begin
        w_ln_sign  = w_d4_sign;
        w_ln_zero  = w_d4_zero;
        w_ln_nar   = w_d4_nar;
        w_ln_scale = w_d4_scale;
        w_ln_frac  = w_d4_frac;
      end
      default: begin
        w_ln_sign = 4'b0000;
      end
    endcase
  end

  // Stage 2 register: decoded lanes, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_err   <= 1'b0;
      r2_pre   <= 2'b00;
      r2_sign  <= 4'b0000;
      r2_zero  <= 4'b0000;
      r2_nar   <= 4'b0000;
      r2_scale <= {(4*SCALE_W){1'b0}};
      r2_frac  <= {(4*FRAC_W){1'b0}};
    end else if (w_ready2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_err   <= r1_err;
        r2_pre   <= r1_pre;
        r2_sign  <= w_ln_sign;
        r2_zero  <= w_ln_zero;
        r2_nar   <= w_ln_nar;
        r2_scale <= w_ln_scale;
        r2_frac  <= w_ln_frac;
      end
    end
  end

  assign out_valid = r2_valid;
  assign out_pre   = r2_pre;
  assign out_err   = r2_err;
  assign out_sign  = r2_sign;
  assign out_zero  = r2_zero;
  assign out_nar   = r2_nar;
  assign out_scale = r2_scale;
  assign out_frac  = r2_frac;

endmodule
